// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t    : fetch FSM state encoding
//   RESET_PC_DEFAULT : default reset PC (word aligned)
//   J_MSB/J_LSB/J_W  : J-type instruction index field bounds
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int J_MSB = 25;
    localparam int J_LSB = 0;
    localparam int J_W   = J_MSB - J_LSB + 1;

endpackage

// File: rtl/ifetch_unit_if.sv
// Bus bundle between the fetch unit and its environment.
//   Memory side : imem_req/imem_addr (out), imem_ack/imem_rdata (in)
//   Decode side : Instruction/inst_valid/PC_plus_4/link_addr (out), inst_ready (in)
//   ALU side    : Zero, Addr_Result, Read_data_1 and control flags (in)
// modport master is the fetch unit; modport slave is memory + decode/ALU.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic [31:0] Instruction;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] PC_plus_4;
    logic [31:0] link_addr;

    logic        Zero;
    logic [31:0] Addr_Result;
    logic [31:0] Read_data_1;
    logic        Branch;
    logic        nBranch;
    logic        Jmp;
    logic        Jal;
    logic        Jr;

    modport master (
        output imem_req, imem_addr, Instruction, inst_valid, PC_plus_4, link_addr,
        input  imem_ack, imem_rdata, inst_ready, Zero, Addr_Result, Read_data_1,
               Branch, nBranch, Jmp, Jal, Jr
    );

    modport slave (
        input  imem_req, imem_addr, Instruction, inst_valid, PC_plus_4, link_addr,
        output imem_ack, imem_rdata, inst_ready, Zero, Addr_Result, Read_data_1,
               Branch, nBranch, Jmp, Jal, Jr
    );
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux.
//   pc_plus_4_i      : PC + 4 of the instruction being accepted
//   j_index_i        : J-type index field of that instruction
//   addr_result_i    : ALU branch target
//   read_data_1_i    : register operand used as jr target
//   branch_i .. jr_i : control flags, zero_i : ALU zero flag
//   next_pc_o        : selected next PC, always word aligned
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [31:0]    pc_plus_4_i,
    input  logic [J_W-1:0] j_index_i,
    input  logic [31:0]    addr_result_i,
    input  logic [31:0]    read_data_1_i,
    input  logic           zero_i,
    input  logic           branch_i,
    input  logic           nbranch_i,
    input  logic           jmp_i,
    input  logic           jal_i,
    input  logic           jr_i,
    output logic [31:0]    next_pc_o
);

    logic [31:0] target_d;
    logic        taken_d;

    always_comb begin
        taken_d  = (branch_i && zero_i) || (nbranch_i && !zero_i);
        target_d = pc_plus_4_i;
        if (jr_i) begin
            target_d = read_data_1_i;
        end else if (jmp_i || jal_i) begin
            // Region-relative jump: keep the top nibble of PC+4.
            target_d = {pc_plus_4_i[31:28], j_index_i, 2'b00};
        end else if (taken_d) begin
            target_d = addr_result_i;
        end
    end

    // Low bits are cleared so a misaligned register or ALU value can
    // never put the fetch address off a word boundary.
    assign next_pc_o = {target_d[31:2], 2'b00};

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC, fetch FSM, instruction and link registers.
//   clock, rst_n : rising-edge clock, asynchronous active-low reset
//   bus          : ifetch_unit_if.master (memory req/ack, decode valid/ready,
//                  ALU/control inputs sampled on the accept cycle)
// Parameter RESET_PC: PC loaded on reset, bits [1:0] must be zero.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic         clock,
    input  logic         rst_n,
    ifetch_unit_if.master bus
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  link_q;
    logic         req_q;
    logic         valid_q;

    logic [31:0]  pc_plus_4_d;
    logic [31:0]  next_pc_d;
    logic         accept_d;

    assign pc_plus_4_d = pc_q + 32'd4;   // wraps modulo 2^32
    assign accept_d    = (state_q == S_HOLD) && bus.inst_ready;

    next_pc_sel u_next_pc_sel (
        .pc_plus_4_i   (pc_plus_4_d),
        .j_index_i     (instr_q[J_MSB:J_LSB]),
        .addr_result_i (bus.Addr_Result),
        .read_data_1_i (bus.Read_data_1),
        .zero_i        (bus.Zero),
        .branch_i      (bus.Branch),
        .nbranch_i     (bus.nBranch),
        .jmp_i         (bus.Jmp),
        .jal_i         (bus.Jal),
        .jr_i          (bus.Jr),
        .next_pc_o     (next_pc_d)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            link_q  <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (accept_d) begin
                        // Redirected address goes out with the very next request,
                        // so a taken branch costs no bubble.
                        pc_q    <= next_pc_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                        if (bus.Jal) begin
                            link_q <= pc_plus_4_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.Instruction = instr_q;
    assign bus.inst_valid  = valid_q;
    assign bus.PC_plus_4   = pc_plus_4_d;
    assign bus.link_addr   = link_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a queue holds expected fetch
// addresses, pushed when the bench accepts an instruction and popped when
// the unit raises its next request.
module tb_ifetch_unit;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   prev_req_cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_link = 32'd0;

    ifetch_unit_if bus_if ();

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        bus_if.inst_ready  = 1'b0;
        bus_if.Branch      = 1'b0;
        bus_if.nBranch     = 1'b0;
        bus_if.Jmp         = 1'b0;
        bus_if.Jal         = 1'b0;
        bus_if.Jr          = 1'b0;
        bus_if.Zero        = 1'b0;
        bus_if.Addr_Result = 32'hDEAD_BEE0;
        bus_if.Read_data_1 = 32'hCAFE_F000;
    endtask

    // One complete fetch/accept transaction.
    task automatic do_fetch(input logic [31:0] rdata, input int ack_dly, input int rdy_dly,
                            input logic chk_thru,
                            input logic br, input logic nbr, input logic jmp,
                            input logic jal, input logic jr, input logic zero,
                            input logic [31:0] addr_res, input logic [31:0] rd1);
        logic [31:0] exp_addr;
        logic [31:0] pc4;
        logic [31:0] t;
        int n;
        n = 0;
        while (bus_if.imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (bus_if.imem_req !== 1'b1) begin
            check_value("req_timeout", {31'd0, bus_if.imem_req}, 32'd1);
            return;
        end
        if (chk_thru) check_value("thruput", cyc - prev_req_cyc, 32'd2);
        prev_req_cyc = cyc;
        exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        pc4 = exp_addr + 32'd4;
        check_value("imem_addr", bus_if.imem_addr, exp_addr);
        for (int i = 0; i < ack_dly; i++) begin
            bus_if.imem_ack = 1'b0;
            step();
            check_value("req_stable", {31'd0, bus_if.imem_req}, 32'd1);
            check_value("addr_stable", bus_if.imem_addr, exp_addr);
        end
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = rdata;
        step();
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = ~rdata;
        check_value("inst_valid", {31'd0, bus_if.inst_valid}, 32'd1);
        check_value("Instruction", bus_if.Instruction, rdata);
        check_value("PC_plus_4", bus_if.PC_plus_4, pc4);
        for (int i = 0; i < rdy_dly; i++) begin
            // Stray ack and control flags while stalled must be ignored.
            bus_if.imem_ack = 1'b1;
            bus_if.Jr       = 1'b1;
            step();
            check_value("stall_instr", bus_if.Instruction, rdata);
            check_value("stall_pc4", bus_if.PC_plus_4, pc4);
        end
        bus_if.imem_ack    = 1'b0;
        bus_if.inst_ready  = 1'b1;
        bus_if.Branch      = br;
        bus_if.nBranch     = nbr;
        bus_if.Jmp         = jmp;
        bus_if.Jal         = jal;
        bus_if.Jr          = jr;
        bus_if.Zero        = zero;
        bus_if.Addr_Result = addr_res;
        bus_if.Read_data_1 = rd1;
        if (jr)                                t = rd1;
        else if (jmp || jal)                   t = {pc4[31:28], rdata[25:0], 2'b00};
        else if ((br && zero) || (nbr && !zero)) t = addr_res;
        else                                   t = pc4;
        t[1:0] = 2'b00;
        exp_q.push_back(t);
        if (jal) exp_link = pc4;
        step();
        clear_ctl();
        check_value("link_addr", bus_if.link_addr, exp_link);
    endtask

    initial begin
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = 32'd0;
        clear_ctl();
        #12;
        check_value("rst_req", {31'd0, bus_if.imem_req}, 32'd0);
        check_value("rst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        check_value("rst_instr", bus_if.Instruction, 32'd0);
        check_value("rst_link", bus_if.link_addr, 32'd0);
        check_value("rst_addr", bus_if.imem_addr, 32'h0);
        check_value("rst_pc4", bus_if.PC_plus_4, 32'h4);
        step();
        rst_n = 1'b1;
        check_value("req_low_after_release", {31'd0, bus_if.imem_req}, 32'd0);
        step();
        check_value("req_rises", {31'd0, bus_if.imem_req}, 32'd1);
        exp_q.push_back(32'h0);

        // Sequential fetch 0,4,8,12 then to 0x10.
        for (int i = 0; i < 4; i++)
            do_fetch(32'h1111_0000 + i, 0, 0, i > 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        // PC 0x10: beq taken -> 0x40, then back via jr.
        do_fetch(32'h1000_0001, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h40, 32'h0);
        do_fetch(32'h2000_0002, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h10);
        // beq not taken -> 0x14
        do_fetch(32'h1000_0003, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h40, 32'h0);
        do_fetch(32'h2000_0004, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h10);
        // bne taken -> 0x40
        do_fetch(32'h1400_0005, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h40, 32'h0);
        do_fetch(32'h2000_0006, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h10);
        // jal at 0x10 -> 0x80, link 0x14
        do_fetch(32'h0C00_0020, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        // Jr beats Jmp, misaligned 0x3E -> 0x3C
        do_fetch(32'h0800_0050, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h3E);
        // Stalls at 0x3C: ack delay 3, ready low 5; then jr to wrap point.
        do_fetch(32'h3333_3333, 3, 5, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC);
        // PC 0xFFFFFFFC: PC_plus_4 wraps to 0, sequential next is 0.
        do_fetch(32'h4444_4444, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        // From 0, jump to 0x20 via jr.
        do_fetch(32'h5555_5555, 1, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h20);

        // Mid-fetch reset while requesting 0x20.
        for (int n = 0; n < 5 && bus_if.imem_req !== 1'b1; n++) step();
        check_value("pre_rst_addr", bus_if.imem_addr, exp_q.size() > 0 ? exp_q.pop_front() : 32'hFFFF_FFFF);
        check_value("pre_rst_req", {31'd0, bus_if.imem_req}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_value("async_req_drop", {31'd0, bus_if.imem_req}, 32'd0);
        check_value("async_addr", bus_if.imem_addr, 32'h0);
        check_value("async_link", bus_if.link_addr, 32'd0);
        check_value("async_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        exp_q.delete();
        exp_link = 32'd0;
        step();
        rst_n = 1'b1;
        exp_q.push_back(32'h0);
        do_fetch(32'h6666_6666, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        do_fetch(32'h7777_7777, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
